// File: rtl/diff2d_stream.sv
// diff2d_stream: streaming 2D backward finite-difference engine.
//
// Takes a raster-order pixel stream (row-major, x fastest). For every accepted pixel it
// produces full-precision backward differences:
//   Dx = u(x,y) - u(x-1,y)    Dy = u(x,y) - u(x,y-1)
// A difference whose neighbour lies outside the frame is forced to zero.
//
// The vertical neighbour is held in a one-row line buffer indexed by column. The horizontal
// neighbour is held in a single previous-pixel register. Results sit in one output register
// with valid/ready backpressure. The register can be refilled in the same cycle that it is
// drained, so the engine sustains one pixel per cycle.
//
// Ports:
//   i_clk, i_reset_n   clock (rising edge) and asynchronous active-low reset
//   i_clear            synchronous frame restart; drops any pending result
//   i_valid/o_ready    input handshake; i_data is the signed pixel
//   o_valid/i_ready    output handshake
//   o_dx, o_dy         signed WIDTH+1 differences
//   o_x, o_y           coordinates of the presented result
//   o_eol, o_eof       last column of a row / last pixel of the frame

module diff2d_stream #(
    parameter int WIDTH = 32,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_dx,
    output logic [WIDTH:0]   o_dy,
    output logic [CW-1:0]    o_x,
    output logic [RW-1:0]    o_y,
    output logic             o_eol,
    output logic             o_eof
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0]    x_q, x_d;
    logic [RW-1:0]    y_q, y_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    logic             valid_q, valid_d;
    logic [WIDTH:0]   dx_q, dx_d;
    logic [WIDTH:0]   dy_q, dy_d;
    logic [CW-1:0]    ox_q, ox_d;
    logic [RW-1:0]    oy_q, oy_d;
    logic             eol_q, eol_d;
    logic             eof_q, eof_d;

    // One row of history. The contents need no reset because row 0 never reads them.
    logic [WIDTH-1:0] lb_q [IMG_W];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic accept;
    logic consume;
    logic last_col;
    logic last_row;

    assign o_ready  = !valid_q || i_ready;
    // A pixel offered during i_clear is discarded. It must not reach the counters or the
    // history registers.
    assign accept   = i_valid && o_ready && !i_clear;
    assign consume  = valid_q && i_ready;
    assign last_col = (x_q == CW'(IMG_W - 1));
    assign last_row = (y_q == RW'(IMG_H - 1));

    // ------------------------------------------------------------------
    // Arithmetic: sign-extend to WIDTH+1 first, so the difference cannot overflow.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]      above;
    logic signed [WIDTH:0] cur_ext;
    logic signed [WIDTH:0] left_ext;
    logic signed [WIDTH:0] above_ext;
    logic signed [WIDTH:0] dx_raw;
    logic signed [WIDTH:0] dy_raw;

    // Combinational read of the entry about to be overwritten (read-before-write).
    assign above     = lb_q[x_q];
    assign cur_ext   = {i_data[WIDTH-1], i_data};
    assign left_ext  = {prev_q[WIDTH-1], prev_q};
    assign above_ext = {above[WIDTH-1], above};
    assign dx_raw    = cur_ext - left_ext;
    assign dy_raw    = cur_ext - above_ext;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        prev_d  = prev_q;
        valid_d = valid_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        eol_d   = eol_q;
        eof_d   = eof_q;

        if (i_clear) begin
            x_d     = '0;
            y_d     = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            // Zero-flux boundary: stale history is never used at x==0 or y==0.
            dx_d    = (x_q == '0) ? '0 : dx_raw;
            dy_d    = (y_q == '0) ? '0 : dy_raw;
            ox_d    = x_q;
            oy_d    = y_q;
            eol_d   = last_col;
            eof_d   = last_col && last_row;
            valid_d = 1'b1;
            prev_d  = i_data;

            if (last_col) begin
                x_d = '0;
                y_d = last_row ? '0 : y_q + RW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            prev_q  <= '0;
            valid_q <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb_q[x_q] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_valid = valid_q;
    assign o_dx    = dx_q;
    assign o_dy    = dy_q;
    assign o_x     = ox_q;
    assign o_y     = oy_q;
    assign o_eol   = eol_q;
    assign o_eof   = eof_q;

endmodule

// File: tb/tb_diff2d_stream.sv
// Directed bench for diff2d_stream at WIDTH=8, 4x3 frames.
// Each expected result is predicted from a whole-frame pixel model when the pixel is
// accepted. It is queued, then compared against the output register while that result is
// presented.

module tb_diff2d_stream;

    localparam int W  = 8;
    localparam int IW = 4;
    localparam int IH = 3;
    localparam int CW = $clog2(IW);
    localparam int RW = $clog2(IH);

    logic          clk;
    logic          i_reset_n;
    logic          i_clear;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_data;
    logic          o_valid;
    logic          i_ready;
    logic [W:0]    o_dx;
    logic [W:0]    o_dy;
    logic [CW-1:0] o_x;
    logic [RW-1:0] o_y;
    logic          o_eol;
    logic          o_eof;

    diff2d_stream #(
        .WIDTH (W),
        .IMG_W (IW),
        .IMG_H (IH)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_clear),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_dx      (o_dx),
        .o_dy      (o_dy),
        .o_x       (o_x),
        .o_y       (o_y),
        .o_eol     (o_eol),
        .o_eof     (o_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W:0]    dx;
        logic [W:0]    dy;
        logic [CW-1:0] x;
        logic [RW-1:0] y;
        logic          eol;
        logic          eof;
    } exp_t;

    exp_t sb[$];
    int   fm [IH][IW];
    int   m_x;
    int   m_y;
    logic m_valid;
    int   n_pass;
    int   n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] pix(input int kind, input int k);
        int x;
        int y;
        int t;
        x = k % IW;
        y = (k / IW) % IH;
        case (kind)
            1: begin
                case (k)
                    0:       t = 127;
                    1:       t = -128;
                    4:       t = -128;
                    5:       t = 127;
                    default: t = x + y;
                endcase
            end
            2:       t = (k < IW * IH) ? x + 4 * y : 100 - x;
            3:       t = x + 4 * y + 10;
            default: t = x + 4 * y;
        endcase
        return t[W-1:0];
    endfunction

    // Model a pixel entering the frame and queue the result it must produce.
    task automatic predict(input logic [W-1:0] d);
        exp_t e;
        int   u;
        int   dx;
        int   dy;
        u  = $signed(d);
        dx = (m_x == 0) ? 0 : u - fm[m_y][m_x-1];
        dy = (m_y == 0) ? 0 : u - fm[m_y-1][m_x];
        fm[m_y][m_x] = u;
        e.dx  = dx[W:0];
        e.dy  = dy[W:0];
        e.x   = m_x[CW-1:0];
        e.y   = m_y[RW-1:0];
        e.eol = (m_x == IW - 1);
        e.eof = (m_x == IW - 1) && (m_y == IH - 1);
        sb.push_back(e);
        if (m_x == IW - 1) begin
            m_x = 0;
            m_y = (m_y == IH - 1) ? 0 : m_y + 1;
        end else begin
            m_x++;
        end
    endtask

    // One clock: drive at negedge, check the presented result, then update the model.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic clr,
                         output logic acc);
        exp_t e;
        logic cons;
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_clear = clr;
        #1;
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        chk("o_ready", 32'(o_ready), 32'(!m_valid || r));
        if (m_valid && sb.size() > 0) begin
            e = sb[0];
            chk("o_dx", 32'(o_dx), 32'(e.dx));
            chk("o_dy", 32'(o_dy), 32'(e.dy));
            chk("o_x", 32'(o_x), 32'(e.x));
            chk("o_y", 32'(o_y), 32'(e.y));
            chk("o_eol", 32'(o_eol), 32'(e.eol));
            chk("o_eof", 32'(o_eof), 32'(e.eof));
        end
        cons = m_valid && r;
        if (cons) void'(sb.pop_front());
        acc = v && (!m_valid || r) && !clr;
        if (clr) begin
            sb.delete();
            m_x = 0;
            m_y = 0;
        end else if (acc) begin
            predict(d);
        end
        m_valid = clr ? 1'b0 : (acc ? 1'b1 : (cons ? 1'b0 : m_valid));
        @(posedge clk);
    endtask

    // rmode: 0 = i_ready held 1, 1 = i_ready pattern 1,0,0,1. vmode: 1 = random i_valid gaps.
    task automatic run_pixels(input int n, input int kind, input int rmode, input int vmode);
        logic [3:0] pat;
        logic       acc;
        logic       v;
        logic       r;
        int         k;
        int         cyc;
        pat = 4'b1001;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 400) begin
            v = (vmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            r = (rmode != 0) ? pat[3 - (cyc % 4)] : 1'b1;
            cycle(v, pix(kind, k), r, 1'b0, acc);
            if (acc) k++;
            cyc++;
        end
        if (k != n) chk("stream_timeout", 32'(k), 32'(n));
    endtask

    task automatic drain();
        logic acc;
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    // Reset pulsed between clock edges while a result is pending.
    task automatic async_reset();
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_clear = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(o_valid), 32'(m_valid));
        #1;
        i_reset_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(o_valid), 32'(0));
        chk("rst_async_dx", 32'(o_dx), 32'(0));
        chk("rst_async_x", 32'(o_x), 32'(0));
        chk("rst_async_eol", 32'(o_eol), 32'(0));
        sb.delete();
        m_valid = 1'b0;
        m_x     = 0;
        m_y     = 0;
        #1;
        i_reset_n = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        logic acc;
        n_pass    = 0;
        n_total   = 0;
        m_x       = 0;
        m_y       = 0;
        m_valid   = 1'b0;
        i_reset_n = 1'b0;
        i_clear   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_data    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'(0));
        chk("rst_ready", 32'(o_ready), 32'(1));
        chk("rst_dx", 32'(o_dx), 32'(0));
        chk("rst_dy", 32'(o_dy), 32'(0));
        chk("rst_x", 32'(o_x), 32'(0));
        chk("rst_y", 32'(o_y), 32'(0));
        chk("rst_eol", 32'(o_eol), 32'(0));
        chk("rst_eof", 32'(o_eof), 32'(0));
        i_reset_n = 1'b1;

        // Ramp frame, full rate
        run_pixels(IW * IH, 0, 0, 0);
        drain();

        // Extremes: width growth to 9 bits
        run_pixels(IW * IH, 1, 0, 0);
        drain();

        // Backpressure with i_valid held high
        run_pixels(IW * IH, 0, 1, 0);
        drain();

        // Random input gaps
        run_pixels(IW * IH, 0, 0, 1);
        drain();

        // Two frames back to back, second is 100-x
        run_pixels(2 * IW * IH, 2, 0, 0);
        drain();

        // Clear offered together with pixel (2,1), then restart from (0,0)
        run_pixels(6, 3, 0, 0);
        cycle(1'b1, pix(3, 6), 1'b1, 1'b1, acc);
        run_pixels(IW * IH, 3, 0, 0);
        drain();

        // Asynchronous reset mid-frame, then restart from (0,0)
        run_pixels(6, 0, 0, 0);
        async_reset();
        run_pixels(IW * IH, 3, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
